// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and default widths for the high-score RAM arbiter
package hs_pkg;

  // Ownership FSM: CPU owns the RAM in ST_CPU and ST_WAIT, the engine in ST_HS and ST_SETTLE.
  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HS     = 2'd2,
    ST_SETTLE = 2'd3
  } hs_arb_state_t;

  localparam int HS_ADDR_W = 12;
  localparam int HS_DATA_W = 8;
  localparam int HS_SETTLE = 2;

endpackage

// File: rtl/hs_read_pipe.sv
// rtl/hs_read_pipe.sv - engine read-data register with address-change aware valid pipeline
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   owned        : engine drives the RAM address this cycle
//   owned_next   : engine will still own the RAM next cycle
//   hs_address   : engine address
//   ram_rdata    : RAM read data (1-cycle registered by the RAM)
//   hs_data_out  : registered read data for the engine
//   hs_valid     : hs_data_out belongs to the current hs_address
module hs_read_pipe
  import hs_pkg::*;
#(
  parameter int ADDR_W = HS_ADDR_W,
  parameter int DATA_W = HS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              owned,
  input  logic              owned_next,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_valid
);

  logic              rd_issued_q, rd_issued_d;
  logic [ADDR_W-1:0] addr_prev_q, addr_prev_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    // Stage 1: the RAM was addressed by the engine last cycle, at addr_prev_q.
    rd_issued_d = owned;
    addr_prev_d = hs_address;

    data_d = data_q;
    if (owned && rd_issued_q) begin
      data_d = ram_rdata;
    end

    // Stage 2: the word being captured now was read at the address still presented,
    // so any address change clears valid for one cycle, and losing ownership clears it
    // on the same edge the owner flag falls.
    valid_d = owned && owned_next && rd_issued_q && (hs_address == addr_prev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_issued_q <= 1'b0;
      addr_prev_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      rd_issued_q <= rd_issued_d;
      addr_prev_q <= addr_prev_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign hs_data_out = data_q;
  assign hs_valid    = valid_q;

endmodule

// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - shares the work-RAM port between the game CPU and the high-score engine
// Ports:
//   clk_49m, reset                     : clock, synchronous active-high reset
//   pause, cpu_cen                     : CPU halted, CPU bus-cycle boundary strobe
//   cpu_cs/we/addr/wdata, cpu_rdata    : CPU work-RAM bus
//   hs_address/data_in/write_enable    : engine address, write data, write strobe
//   hs_access_write/read               : engine access intent (request)
//   hs_data_out, hs_valid              : engine read data and its validity
//   hs_owner, hs_dropped               : engine owns RAM, sticky discarded-write flag
//   ram_addr/we/wdata, ram_rdata       : single work-RAM port
module hs_ram_arbiter
  import hs_pkg::*;
#(
  parameter int ADDR_W = HS_ADDR_W,
  parameter int DATA_W = HS_DATA_W,
  parameter int SETTLE = HS_SETTLE
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              pause,
  input  logic              cpu_cen,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write_enable,
  input  logic              hs_access_write,
  input  logic              hs_access_read,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_valid,
  output logic              hs_owner,
  output logic              hs_dropped,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  hs_arb_state_t    state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             owner_q, owner_d;
  logic             dropped_q, dropped_d;
  logic             hs_req;
  logic             owned;
  logic             hs_we_ok;

  assign hs_req  = hs_access_read | hs_access_write;
  assign owned   = (state_q == ST_HS) || (state_q == ST_SETTLE);
  assign cnt_inc = settle_cnt_q + 1'b1;

  // An engine write lands only while owned, still paused, and declared as a write;
  // a pause fall in the same cycle therefore discards the strobe.
  assign hs_we_ok = owned & pause & hs_access_write & hs_write_enable;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    unique case (state_q)
      ST_CPU: begin
        if (hs_req && pause) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!pause)       state_d = ST_CPU;
        else if (cpu_cen) state_d = ST_HS;
      end
      ST_HS: begin
        if (!pause) begin
          state_d = ST_CPU;
        end else if (!hs_req) begin
          // This idle cycle is the first one counted towards release.
          if (SETTLE <= 1) begin
            state_d = ST_CPU;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!pause) begin
          state_d = ST_CPU;
        end else if (hs_req) begin
          state_d = ST_HS;
        end else if (cnt_inc >= SETTLE_C) begin
          state_d = ST_CPU;
        end else begin
          settle_cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_CPU;
    endcase

    owner_d   = (state_d == ST_HS) || (state_d == ST_SETTLE);
    dropped_d = dropped_q | (hs_write_enable & ~hs_we_ok);
  end

  // RAM port mux; the CPU has no write path while the engine owns the RAM.
  always_comb begin
    if (owned) begin
      ram_addr  = hs_address;
      ram_wdata = hs_data_in;
      ram_we    = hs_we_ok;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_cs & cpu_we;
    end
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q      <= ST_CPU;
      settle_cnt_q <= '0;
      owner_q      <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      owner_q      <= owner_d;
      dropped_q    <= dropped_d;
    end
  end

  hs_read_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_read_pipe (
    .clk         (clk_49m),
    .reset       (reset),
    .owned       (owned),
    .owned_next  (owner_d),
    .hs_address  (hs_address),
    .ram_rdata   (ram_rdata),
    .hs_data_out (hs_data_out),
    .hs_valid    (hs_valid)
  );

  assign cpu_rdata  = ram_rdata;
  assign hs_owner   = owner_q;
  assign hs_dropped = dropped_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - directed self-checking bench for hs_ram_arbiter
module tb_hs_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pause, cpu_cen, cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in, hs_data_out;
  logic          hs_write_enable, hs_access_write, hs_access_read;
  logic          hs_valid, hs_owner, hs_dropped;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Work RAM with a 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  hs_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(2)) dut (
    .clk_49m         (clk),
    .reset           (reset),
    .pause           (pause),
    .cpu_cen         (cpu_cen),
    .cpu_cs          (cpu_cs),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .hs_address      (hs_address),
    .hs_data_in      (hs_data_in),
    .hs_write_enable (hs_write_enable),
    .hs_access_write (hs_access_write),
    .hs_access_read  (hs_access_read),
    .hs_data_out     (hs_data_out),
    .hs_valid        (hs_valid),
    .hs_owner        (hs_owner),
    .hs_dropped      (hs_dropped),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; cpu_cen = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 8'h99;
    hs_address = '0; hs_data_in = '0; hs_write_enable = 1'b0;
    hs_access_write = 1'b0; hs_access_read = 1'b0;
    tick(); tick();
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL reset_owner: got %b want 0", hs_owner); end
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", hs_valid); end
    n_cmp++; if (hs_dropped !== 1'b0) begin n_bad++; $display("FAIL reset_dropped: got %b want 0", hs_dropped); end
    n_cmp++; if (hs_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", hs_data_out); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_grant();
    pause = 1'b1; hs_access_read = 1'b1; hs_address = 12'h123;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL grant_early_%0d: got %b want 0", i, hs_owner); end
      tick();
    end
    cpu_cen = 1'b1;
    #1;
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL grant_at_cen: got %b want 0", hs_owner); end
    tick();
    cpu_cen = 1'b0;
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL grant_owner: got %b want 1", hs_owner); end
  endtask

  task automatic test_read();
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL read_valid_c0: got %b want 0", hs_valid); end
    tick();
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL read_valid_c1: got %b want 0", hs_valid); end
    tick();
    n_cmp++; if (hs_valid !== 1'b1) begin n_bad++; $display("FAIL read_valid_c2: got %b want 1", hs_valid); end
    n_cmp++; if (hs_data_out !== 8'hA5) begin n_bad++; $display("FAIL read_data_123: got %h want a5", hs_data_out); end
    hs_address = 12'h124;
    #1;
    n_cmp++; if (ram_addr !== 12'h124) begin n_bad++; $display("FAIL read_ram_addr: got %h want 124", ram_addr); end
    tick();
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL read_chg_valid_c1: got %b want 0", hs_valid); end
    tick();
    n_cmp++; if (hs_valid !== 1'b1) begin n_bad++; $display("FAIL read_chg_valid_c2: got %b want 1", hs_valid); end
    n_cmp++; if (hs_data_out !== 8'h5A) begin n_bad++; $display("FAIL read_data_124: got %h want 5a", hs_data_out); end
    hs_address = 12'hFFF;
    #1;
    n_cmp++; if (ram_addr !== 12'hFFF) begin n_bad++; $display("FAIL read_ram_addr_max: got %h want fff", ram_addr); end
    tick(); tick();
    n_cmp++; if (hs_data_out !== 8'hC3 || hs_valid !== 1'b1) begin
      n_bad++; $display("FAIL read_data_fff: got %h/%b want c3/1", hs_data_out, hs_valid);
    end
  endtask

  task automatic test_write();
    hs_access_write = 1'b1; hs_address = 12'h010; hs_data_in = 8'h3C; hs_write_enable = 1'b1;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'hFF;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL write_ram_we: got %b want 1", ram_we); end
    n_cmp++; if (ram_wdata !== 8'h3C) begin n_bad++; $display("FAIL write_ram_wdata: got %h want 3c", ram_wdata); end
    tick();
    hs_write_enable = 1'b0; hs_access_write = 1'b0;
    cpu_cs = 1'b0; cpu_we = 1'b0;
    n_cmp++; if (mem[12'h010] !== 8'h3C) begin n_bad++; $display("FAIL write_mem_010: got %h want 3c", mem[12'h010]); end
    n_cmp++; if (hs_dropped !== 1'b0) begin n_bad++; $display("FAIL write_dropped: got %b want 0", hs_dropped); end
  endtask

  task automatic test_settle();
    hs_access_read = 1'b0;
    tick();
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL settle_hold_c1: got %b want 1", hs_owner); end
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h77;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL settle_cpu_ignored: got %b want 0", ram_we); end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    hs_access_read = 1'b1;
    tick();
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL settle_hold_c2: got %b want 1", hs_owner); end
    hs_access_read = 1'b0;
    tick();
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL release_c1: got %b want 1", hs_owner); end
    tick();
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL release_c2: got %b want 0", hs_owner); end
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", hs_valid); end
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h77; cpu_cen = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL release_cpu_we: got %b want 1", ram_we); end
    tick();
    cpu_we = 1'b0; cpu_addr = 12'h010; cpu_cen = 1'b0;
    n_cmp++; if (mem[12'h020] !== 8'h77) begin n_bad++; $display("FAIL release_mem_020: got %h want 77", mem[12'h020]); end
    tick();
    n_cmp++; if (cpu_rdata !== 8'h3C) begin n_bad++; $display("FAIL release_cpu_read: got %h want 3c", cpu_rdata); end
    cpu_cs = 1'b0;
  endtask

  task automatic test_abort();
    hs_access_write = 1'b1;
    tick();
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL abort_owner_pre: got %b want 1", hs_owner); end
    pause = 1'b0; hs_write_enable = 1'b1; hs_address = 12'h030; hs_data_in = 8'hEE;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL abort_ram_we: got %b want 0", ram_we); end
    tick();
    hs_write_enable = 1'b0; hs_access_write = 1'b0;
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL abort_owner: got %b want 0", hs_owner); end
    n_cmp++; if (hs_dropped !== 1'b1) begin n_bad++; $display("FAIL abort_dropped: got %b want 1", hs_dropped); end
    n_cmp++; if (mem[12'h030] !== 8'h11) begin n_bad++; $display("FAIL abort_mem_030: got %h want 11", mem[12'h030]); end
  endtask

  task automatic test_reset_in_settle();
    pause = 1'b1; hs_access_read = 1'b1; hs_address = 12'h123;
    tick();
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    tick(); tick();
    n_cmp++; if (hs_valid !== 1'b1 || hs_data_out !== 8'hA5) begin
      n_bad++; $display("FAIL rst_pre_read: got %b/%h want 1/a5", hs_valid, hs_data_out);
    end
    hs_access_read = 1'b0;
    tick();
    n_cmp++; if (hs_owner !== 1'b1) begin n_bad++; $display("FAIL rst_pre_owner: got %b want 1", hs_owner); end
    n_cmp++; if (hs_dropped !== 1'b1) begin n_bad++; $display("FAIL rst_pre_sticky: got %b want 1", hs_dropped); end
    reset = 1'b1;
    tick();
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL rst_owner: got %b want 0", hs_owner); end
    n_cmp++; if (hs_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", hs_valid); end
    n_cmp++; if (hs_dropped !== 1'b0) begin n_bad++; $display("FAIL rst_dropped: got %b want 0", hs_dropped); end
    n_cmp++; if (hs_data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %h want 00", hs_data_out); end
    reset = 1'b0;
    tick();
    n_cmp++; if (hs_owner !== 1'b0) begin n_bad++; $display("FAIL rst_post_owner: got %b want 0", hs_owner); end
  endtask

  task automatic test_drop_outside();
    pause = 1'b0; hs_access_write = 1'b1; hs_write_enable = 1'b1;
    hs_address = 12'h040; hs_data_in = 8'h66;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL drop_out_ram_we: got %b want 0", ram_we); end
    tick();
    hs_write_enable = 1'b0; hs_access_write = 1'b0;
    n_cmp++; if (hs_dropped !== 1'b1) begin n_bad++; $display("FAIL drop_out_dropped: got %b want 1", hs_dropped); end
    n_cmp++; if (mem[12'h040] !== 8'h00) begin n_bad++; $display("FAIL drop_out_mem: got %h want 00", mem[12'h040]); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h123] = 8'hA5;
    mem[12'h124] = 8'h5A;
    mem[12'hFFF] = 8'hC3;
    mem[12'h030] = 8'h11;
    test_reset();
    test_grant();
    test_read();
    test_write();
    test_settle();
    test_abort();
    test_reset_in_settle();
    test_drop_outside();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
